dmem_arbiter: RTL

//  Shares the single data_memory port between two requesters: port 0 (core load/store

---
 rtl/dmem_arbiter.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of the single data_memory port.
// Each accepted request takes three cycles: IDLE (accept), ACCESS (memory), RESP (pulse).
module dmem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_LOCS   = 64
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  input  logic                  req0_write,
  input  logic [1:0]            req0_type,
  input  logic                  req0_unsigned,
  output logic                  rsp0_valid,
  output logic [DATA_WIDTH-1:0] rsp0_rdata,
  output logic                  rsp0_err,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  input  logic                  req1_write,
  input  logic [1:0]            req1_type,
  input  logic                  req1_unsigned,
  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp1_rdata,
  output logic                  rsp1_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [1:0]            load_store_type,
  output logic                  load_unsigned,
  input  logic [DATA_WIDTH-1:0] mem_read_data
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  write;
    logic [1:0]            typ;
    logic                  uns;
    logic                  port;
  } req_t;

  localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH+1)'(NUM_LOCS * 4);

  state_t                state, state_nxt;
  logic                  last_grant;
  req_t                  req_q, req_sel;
  logic                  range_err_q, range_err_sel;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  winner, accept;
  logic [ADDR_WIDTH:0]   last_byte;
  logic [ADDR_WIDTH:0]   extra_bytes;
  logic                  rsp_legal_load;
  logic [DATA_WIDTH-1:0] rsp_rdata;

  // Arbitration, payload mux and range check for the request being accepted.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    winner = req1_valid;
    if (req0_valid && req1_valid) winner = ~last_grant;
    accept = (state == IDLE) && (req0_valid || req1_valid);

    req_sel = '0;
    if (winner) begin
      req_sel.addr  = req1_addr;
      req_sel.wdata = req1_wdata;
      req_sel.write = req1_write;
      req_sel.typ   = req1_type;
      req_sel.uns   = req1_unsigned;
      req_sel.port  = 1'b1;
    end else begin
      req_sel.addr  = req0_addr;
      req_sel.wdata = req0_wdata;
      req_sel.write = req0_write;
      req_sel.typ   = req0_type;
      req_sel.uns   = req0_unsigned;
      req_sel.port  = 1'b0;
    end

    // Type 11 is treated as a single byte for the range check.
    case (req_sel.typ)
      2'b01:   extra_bytes = (ADDR_WIDTH+1)'(1);
      2'b10:   extra_bytes = (ADDR_WIDTH+1)'(3);
      default: extra_bytes = '0;
    endcase
    // One extra bit so an access that wraps past the top of the address space is caught.
    last_byte     = {1'b0, req_sel.addr} + extra_bytes;
    range_err_sel = (last_byte >= LIMIT);
  end

  assign req0_ready = accept && !winner;
  assign req1_ready = accept &&  winner;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ACCESS;
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      req_q       <= '0;
      range_err_q <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        req_q       <= req_sel;
        range_err_q <= range_err_sel;
        last_grant  <= winner;
      end
      if (state == ACCESS) rdata_q <= mem_read_data;
    end
  end

  // Memory side: only ACCESS drives anything, and an out-of-range request never strobes.
  always_comb begin
    mem_addr        = '0;
    mem_write_data  = '0;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    load_store_type = 2'b00;
    load_unsigned   = 1'b0;
    if (state == ACCESS) begin
      mem_addr        = req_q.addr;
      mem_write_data  = req_q.wdata;
      load_store_type = req_q.typ;
      load_unsigned   = req_q.uns;
      mem_read        = !range_err_q && !req_q.write;
      mem_write       = !range_err_q &&  req_q.write;
    end
  end

  assign rsp_legal_load = !range_err_q && !req_q.write;
  assign rsp_rdata      = rsp_legal_load ? rdata_q : '0;

  always_comb begin
    rsp0_valid = 1'b0;
    rsp0_rdata = '0;
    rsp0_err   = 1'b0;
    rsp1_valid = 1'b0;
    rsp1_rdata = '0;
    rsp1_err   = 1'b0;
    if (state == RESP) begin
      if (req_q.port) begin
        rsp1_valid = 1'b1;
        rsp1_rdata = rsp_rdata;
        rsp1_err   = range_err_q;
      end else begin
        rsp0_valid = 1'b1;
        rsp0_rdata = rsp_rdata;
        rsp0_err   = range_err_q;
      end
    end
  end

endmodule
